// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-macro signals of the shared memory port
//   master: core-and-memory side (drives requests and mem_rdata, receives ready/rdata and strobes)
//   slave : arbiter side (receives requests and mem_rdata, drives ready/rdata and strobes)
//   i_*   : instruction-fetch requester (req/addr in, ready/rdata out)
//   d_*   : data load/store requester (req/we/addr/wdata in, ready/rdata out)
//   mem_* : single-port synchronous word memory (en/we/addr/wdata out, rdata in)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 10
);
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_ready;
   logic [31:0]       i_rdata;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_ready;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ready, i_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency single-port word memory between fetch and data
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave, fetch/data request ports and memory macro port
//   busy  : high whenever an access is in flight (state != IDLE)
//   owner : requester of the current/last access, 0 = fetch, 1 = data
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus,
   output logic              busy,
   output logic              owner
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t            r_state;
   logic [7:0]        r_cnt;
   logic              r_owner;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_i_ready;
   logic              r_d_ready;
   logic [31:0]       r_i_rdata;
   logic [31:0]       r_d_rdata;
   logic              w_req;
   logic              w_gnt_d;
   logic              w_unused;
   assign w_req    = bus.i_req | bus.d_req;
   // on a tie the grant goes to whoever did not own the last access
   assign w_gnt_d  = bus.d_req & (~bus.i_req | ~r_owner);
   assign w_unused = &{1'b0, bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                       bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= 8'd0;
         r_owner     <= 1'b1;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_i_ready   <= 1'b0;
         r_d_ready   <= 1'b0;
         r_i_rdata   <= 32'd0;
         r_d_rdata   <= 32'd0;
      end else begin
         case (r_state)
            IDLE: if (w_req) begin
               r_owner     <= w_gnt_d;
               r_mem_addr  <= w_gnt_d ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
               r_mem_we    <= w_gnt_d & bus.d_we;
               r_mem_wdata <= bus.d_wdata;
               r_mem_en    <= 1'b1;
               r_cnt       <= 8'(MEM_LATENCY);
               r_state     <= BUSY;
            end
            BUSY: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               // counting down to zero places the capture edge at the end of the
               // cycle MEM_LATENCY after the strobe, when the macro drives rdata
               if (r_cnt == 8'd0) begin
                  if (r_owner) r_d_rdata <= bus.mem_rdata;
                  else         r_i_rdata <= bus.mem_rdata;
                  r_i_ready <= ~r_owner;
                  r_d_ready <= r_owner;
                  r_state   <= RESP;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_i_ready <= 1'b0;
               r_d_ready <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.i_ready   = r_i_ready;
   assign bus.d_ready   = r_d_ready;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign busy          = r_state != IDLE;
   assign owner         = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and random traffic against a memory-level reference
module tb_mem_port_arbiter;
   localparam int LA = 1;
   localparam int LB = 3;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a, rst_b, busy_a, own_a, busy_b, own_b;
   int total = 0;
   int bad = 0;
   mem_port_arbiter_if #(.ADDR_W(10)) ba ();
   mem_port_arbiter_if #(.ADDR_W(10)) bb ();
   mem_port_arbiter #(.MEM_LATENCY(LA), .ADDR_W(10)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ba.slave), .busy(busy_a), .owner(own_a));
   mem_port_arbiter #(.MEM_LATENCY(LB), .ADDR_W(10)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bb.slave), .busy(busy_b), .owner(own_b));

   function automatic logic [31:0] pat(input int x);
      return (x == 1) ? 32'h00A00093 : (32'h5A000000 | 32'(x));
   endfunction

   // memory macros: read data is valid only in the cycle exactly L after the strobe
   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];
   bit          wr_a [1024];
   bit          wr_b [1024];
   logic [31:0] v_a, v_b;
   int k_a = 0;
   int k_b = 0;
   always @(posedge clk) begin
      if (ba.mem_en) begin
         v_a <= wr_a[ba.mem_addr] ? mem_a[ba.mem_addr] : pat(int'(ba.mem_addr));
         k_a <= 1;
         if (ba.mem_we) begin
            mem_a[ba.mem_addr] <= ba.mem_wdata;
            wr_a[ba.mem_addr]  <= 1'b1;
         end
      end else if (k_a > 0) k_a <= k_a + 1;
      if (bb.mem_en) begin
         v_b <= wr_b[bb.mem_addr] ? mem_b[bb.mem_addr] : pat(int'(bb.mem_addr));
         k_b <= 1;
         if (bb.mem_we) begin
            mem_b[bb.mem_addr] <= bb.mem_wdata;
            wr_b[bb.mem_addr]  <= 1'b1;
         end
      end else if (k_b > 0) k_b <= k_b + 1;
   end
   assign ba.mem_rdata = (k_a == LA) ? v_a : 32'hBAD0BAD0;
   assign bb.mem_rdata = (k_b == LB) ? v_b : 32'hBAD0BAD0;

   // reference memory for the random phase, updated when each access completes
   logic [31:0] rm [1024];
   bit          rw [1024];
   function automatic logic [31:0] refrd(input logic [31:0] a);
      return rw[a[11:2]] ? rm[a[11:2]] : pat(int'(a[11:2]));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   typedef struct {
      bit          isd;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [9:0]  ema;
      bit          chkd;
      logic [31:0] erd;
   } vec_t;
   vec_t tv [9];

   task automatic run_txn(input vec_t v, output int t_en, output int t_rdy, output logic [9:0] ma,
                          output bit mw, output bit side, output logic [31:0] rd);
      t_en = -1; t_rdy = -1; ma = '0; mw = 0; side = 0; rd = '0;
      if (v.isd) begin
         ba.d_req = 1; ba.d_we = v.we; ba.d_addr = v.addr; ba.d_wdata = v.wdata;
      end else begin
         ba.i_req = 1; ba.i_addr = v.addr;
      end
      for (int c = 1; c <= 40 && t_rdy < 0; c++) begin
         tick;
         if (ba.mem_en && t_en < 0) begin
            t_en = c; ma = ba.mem_addr; mw = ba.mem_we;
         end
         if (ba.i_ready || ba.d_ready) begin
            t_rdy = c; side = ba.d_ready; rd = ba.d_ready ? ba.d_rdata : ba.i_rdata;
         end
      end
      ba.i_req = 0; ba.d_req = 0;
      tick;
   endtask

   initial begin
      int g, n, e, r, t_en, t_rdy;
      logic [3:0] seq;
      logic [9:0] ma;
      logic [31:0] rd;
      bit mw, side;
      bit ai, ad, adw, li, ld, po, exp_o;
      logic [31:0] aia, ada, adwd;
      int si, sd;
      tv[0] = '{1'b0, 1'b0, 32'h00400004, 32'h0,        10'd1,   1'b1, 32'h00A00093};
      tv[1] = '{1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, 10'd4,   1'b0, 32'h0};
      tv[2] = '{1'b1, 1'b0, 32'h00000010, 32'h0,        10'd4,   1'b1, 32'hDEADBEEF};
      tv[3] = '{1'b1, 1'b0, 32'h00000013, 32'h0,        10'd4,   1'b1, 32'hDEADBEEF};
      tv[4] = '{1'b0, 1'b0, 32'hFFFF0010, 32'h0,        10'd4,   1'b1, 32'hDEADBEEF};
      tv[5] = '{1'b1, 1'b1, 32'h00000FFC, 32'h12345678, 10'd1023, 1'b0, 32'h0};
      tv[6] = '{1'b0, 1'b0, 32'h00000FFC, 32'h0,        10'd1023, 1'b1, 32'h12345678};
      tv[7] = '{1'b1, 1'b0, 32'h00000008, 32'h0,        10'd2,   1'b1, 32'h5A000002};
      tv[8] = '{1'b0, 1'b0, 32'h00001000, 32'h0,        10'd0,   1'b1, 32'h5A000000};
      ba.i_req = 0; ba.i_addr = 0; ba.d_req = 0; ba.d_we = 0; ba.d_addr = 0; ba.d_wdata = 0;
      bb.i_req = 0; bb.i_addr = 0; bb.d_req = 0; bb.d_we = 0; bb.d_addr = 0; bb.d_wdata = 0;
      rst_a = 0; rst_b = 0;
      // both requesters pending straight out of reset
      ba.i_req = 1; ba.i_addr = 32'h100; ba.d_req = 1; ba.d_addr = 32'h104;
      repeat (2) tick;
      chk("rst busy", 32'(busy_a), 0);
      chk("rst mem_en", 32'(ba.mem_en), 0);
      chk("rst mem_we", 32'(ba.mem_we), 0);
      chk("rst owner", 32'(own_a), 1);
      chk("rst ready", 32'({ba.i_ready, ba.d_ready}), 0);
      chk("rst mem_addr", 32'(ba.mem_addr), 0);
      chk("rst rdata", ba.i_rdata | ba.d_rdata, 0);
      chk("rst wdata", ba.mem_wdata, 0);
      rst_a = 1; rst_b = 1;
      g = 0; seq = '0;
      for (int c = 0; c < 100 && g < 4; c++) begin
         tick;
         chk("t3 one ready", 32'(ba.i_ready & ba.d_ready), 0);
         if (ba.mem_en) begin
            seq[g] = own_a; g++;
         end
      end
      ba.i_req = 0; ba.d_req = 0;
      chk("t3 grants", g, 4);
      chk("t3 owner seq", 32'(seq), 32'b1010);
      repeat (8) tick;
      foreach (tv[i]) begin
         run_txn(tv[i], t_en, t_rdy, ma, mw, side, rd);
         chk($sformatf("v%0d en cycle", i), t_en, 1);
         chk($sformatf("v%0d ready cycle", i), t_rdy, LA + 2);
         chk($sformatf("v%0d mem_addr", i), 32'(ma), 32'(tv[i].ema));
         chk($sformatf("v%0d mem_we", i), 32'(mw), 32'(tv[i].isd & tv[i].we));
         chk($sformatf("v%0d ready side", i), 32'(side), 32'(tv[i].isd));
         if (tv[i].chkd) chk($sformatf("v%0d rdata", i), rd, tv[i].erd);
      end
      // data held permanently, one fetch slipped in
      ba.d_req = 1; ba.d_we = 0; ba.d_addr = 32'h10;
      repeat (2) tick;
      ba.i_req = 1; ba.i_addr = 32'h00400004;
      n = 0;
      while (!ba.i_ready && n < 50) begin
         tick; n++;
         chk("t4 one ready", 32'(ba.i_ready & ba.d_ready), 0);
      end
      chk("t4 fetch served in time", 32'(n <= 2 * (LA + 3)), 1);
      chk("t4 fetch data", ba.i_rdata, 32'h00A00093);
      ba.i_req = 0; ba.d_req = 0;
      for (int c = 0; c < 20 && busy_a; c++) tick;
      chk("t4 idle", 32'(busy_a), 0);
      // reset in the second BUSY cycle abandons the access
      ba.d_req = 1; ba.d_we = 0; ba.d_addr = 32'h10;
      repeat (2) tick;
      chk("t5 busy before rst", 32'(busy_a), 1);
      rst_a = 0;
      #1;
      chk("t5 busy", 32'(busy_a), 0);
      chk("t5 mem_en", 32'(ba.mem_en), 0);
      chk("t5 owner", 32'(own_a), 1);
      chk("t5 mem_addr", 32'(ba.mem_addr), 0);
      chk("t5 d_rdata", ba.d_rdata, 0);
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("t5 no ready in rst", 32'({ba.i_ready, ba.d_ready}), 0);
      end
      rst_a = 1;
      n = 0;
      while (!ba.d_ready && n < 20) begin
         tick; n++;
         chk("t5 no fetch ready", 32'(ba.i_ready), 0);
      end
      chk("t5 reserve latency", n, LA + 2);
      chk("t5 reserve data", ba.d_rdata, 32'hDEADBEEF);
      ba.d_req = 0;
      tick;
      // latency 3 instance
      chk("t6 rst owner", 32'(own_b), 1);
      bb.d_req = 1; bb.d_we = 0; bb.d_addr = 32'h20;
      e = -1; r = -1; rd = '0;
      for (int c = 1; c <= 30 && r < 0; c++) begin
         tick;
         if (bb.mem_en && e < 0) e = c;
         if (bb.d_ready) begin
            r = c; rd = bb.d_rdata;
         end
      end
      bb.d_req = 0;
      chk("t6 en cycle", e, 1);
      chk("t6 ready cycle", r, LB + 2);
      chk("t6 rdata", rd, 32'h5A000008);
      // random traffic on words 128..191, never touched above
      ai = 0; ad = 0; adw = 0; li = 0; ld = 0; po = 1;
      aia = '0; ada = '0; adwd = '0; si = 0; sd = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick;
         chk("rnd one ready", 32'(ba.i_ready & ba.d_ready), 0);
         if (ba.mem_en) begin
            exp_o = (li && ld) ? !po : ld;
            chk("rnd owner", 32'(own_a), 32'(exp_o));
            chk("rnd mem_addr", 32'(ba.mem_addr), 32'(exp_o ? ada[11:2] : aia[11:2]));
            chk("rnd mem_we", 32'(ba.mem_we), 32'(exp_o & adw));
            if (exp_o && adw) chk("rnd mem_wdata", ba.mem_wdata, adwd);
            po = exp_o;
         end
         if (ba.i_ready) begin
            chk("rnd fetch pending", 32'(ai), 1);
            chk("rnd fetch data", ba.i_rdata, refrd(aia));
            chk("rnd fetch latency", 32'(cyc - si <= 2 * (LA + 3)), 1);
            ai = 0; ba.i_req = 0;
         end
         if (ba.d_ready) begin
            chk("rnd data pending", 32'(ad), 1);
            if (adw) begin
               rm[ada[11:2]] = adwd; rw[ada[11:2]] = 1;
            end else chk("rnd load data", ba.d_rdata, refrd(ada));
            chk("rnd data latency", 32'(cyc - sd <= 2 * (LA + 3)), 1);
            ad = 0; ba.d_req = 0;
         end
         if (!ai && $urandom_range(0, 2) == 0) begin
            aia = ($urandom & 32'hFFFFF003) | ((32'd128 + $urandom_range(0, 63)) << 2);
            ai = 1; si = cyc; ba.i_req = 1; ba.i_addr = aia;
         end
         if (!ad && $urandom_range(0, 2) == 0) begin
            ada = ($urandom & 32'hFFFFF003) | ((32'd128 + $urandom_range(0, 63)) << 2);
            adw = 1'($urandom_range(0, 1)); adwd = $urandom;
            ad = 1; sd = cyc; ba.d_req = 1; ba.d_we = adw; ba.d_addr = ada; ba.d_wdata = adwd;
         end
         li = ai; ld = ad;
      end
      ba.i_req = 0; ba.d_req = 0;
      for (int c = 0; c < 20 && busy_a; c++) tick;
      chk("end idle", 32'(busy_a), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
